// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, drives synchronous imem,
// applies hazard-unit holds and ID-stage redirects, and raises a stall while the first read lands.
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR        = 32'h0000_0000,
    parameter int unsigned RESET_WAIT_CYCLES = 1,
    parameter logic [31:0] NOP_INST          = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall_pc,
    input  logic        i_stall_if_id,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    output logic [31:0] o_imem_raddr,
    output logic        o_imem_ren,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_if_id_inst,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_pc4,
    output logic        o_if_id_valid,
    output logic        o_rst_stall,
    output logic        o_misaligned,
    output logic [31:0] o_fetch_count
);

    localparam logic [0:0] StWait   = 1'b0;
    localparam logic [0:0] StRun    = 1'b1;
    localparam logic [3:0] WaitLast = 4'(RESET_WAIT_CYCLES - 1);

    logic [0:0]  r_state;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;
    logic        r_valid;
    logic        r_misaligned;
    logic [31:0] r_fetch_count;

    logic        w_wait;
    logic [31:0] w_pc4;
    logic [31:0] w_next_pc;
    logic        w_load_inst;
    logic        w_load_bubble;

    assign w_wait = (r_state == StWait);
    assign w_pc4  = r_pc + 32'd4;

    // Redirect beats the PC hold; a held PC re-reads the same word so rdata stays stable.
    always_comb begin
        w_next_pc = w_pc4;
        if (w_wait) begin
            w_next_pc = RESET_ADDR;
        end else if (i_redirect) begin
            w_next_pc = {i_redirect_target[31:2], 2'b00};
        end else if (i_stall_pc) begin
            w_next_pc = r_pc;
        end
    end

    assign w_load_inst   = !i_stall_if_id && !w_wait && !i_redirect;
    assign w_load_bubble = !i_stall_if_id && (w_wait || i_redirect);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StWait;
            r_wait_cnt <= 4'd0;
        end else if (w_wait) begin
            if (r_wait_cnt == WaitLast) begin
                r_state <= StRun;
            end else begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_ADDR;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inst        <= NOP_INST;
            r_id_pc       <= 32'd0;
            r_id_pc4      <= 32'd0;
            r_valid       <= 1'b0;
            r_fetch_count <= 32'd0;
        end else if (w_load_bubble) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (w_load_inst) begin
            r_inst        <= i_imem_rdata;
            r_id_pc       <= r_pc;
            r_id_pc4      <= w_pc4;
            r_valid       <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_misaligned <= 1'b0;
        end else if (!w_wait && i_redirect && (i_redirect_target[1:0] != 2'b00)) begin
            r_misaligned <= 1'b1;
        end
    end

    assign o_imem_raddr  = w_next_pc;
    assign o_imem_ren    = i_rst_n;
    assign o_rst_stall   = w_wait;
    assign o_if_id_inst  = r_inst;
    assign o_if_id_pc    = r_id_pc;
    assign o_if_id_pc4   = r_id_pc4;
    assign o_if_id_valid = r_valid;
    assign o_misaligned  = r_misaligned;
    assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: an instruction-stream model queues the expected IF/ID contents
// per edge and a monitor process compares them against the DUT.
module tb_fetch_unit;

    localparam logic [31:0] RstAddr = 32'h0000_0100;
    localparam int unsigned WaitCyc = 1;
    localparam logic [31:0] Nop     = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_stall_pc = 1'b0;
    logic        i_stall_if_id = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_target = 32'd0;
    logic [31:0] o_imem_raddr;
    logic        o_imem_ren;
    logic [31:0] i_imem_rdata = 32'd0;
    logic [31:0] o_if_id_inst;
    logic [31:0] o_if_id_pc;
    logic [31:0] o_if_id_pc4;
    logic        o_if_id_valid;
    logic        o_rst_stall;
    logic        o_misaligned;
    logic [31:0] o_fetch_count;

    fetch_unit #(
        .RESET_ADDR       (RstAddr),
        .RESET_WAIT_CYCLES(WaitCyc),
        .NOP_INST         (Nop)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_stall_pc       (i_stall_pc),
        .i_stall_if_id    (i_stall_if_id),
        .i_redirect       (i_redirect),
        .i_redirect_target(i_redirect_target),
        .o_imem_raddr     (o_imem_raddr),
        .o_imem_ren       (o_imem_ren),
        .i_imem_rdata     (i_imem_rdata),
        .o_if_id_inst     (o_if_id_inst),
        .o_if_id_pc       (o_if_id_pc),
        .o_if_id_pc4      (o_if_id_pc4),
        .o_if_id_valid    (o_if_id_valid),
        .o_rst_stall      (o_rst_stall),
        .o_misaligned     (o_misaligned),
        .o_fetch_count    (o_fetch_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
    endfunction

    always @(posedge i_clk) begin
        if (o_imem_ren) i_imem_rdata <= mem_word(o_imem_raddr);
    end

    always @(posedge i_clk) begin
        if (i_rst_n && !o_rst_stall)
            assert (!(i_redirect && i_stall_if_id))
            else $error("FAIL redirect_with_ifid_hold: illegal hazard combination in RUN");
    end

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] cnt;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Model of the instruction stream: address being fetched, cycles since release, IF/ID view.
    logic [31:0] m_f;
    int unsigned m_since;
    exp_t        m_id;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always begin
        exp_t e;
        @(posedge i_clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("if_id_valid", {31'd0, o_if_id_valid}, {31'd0, e.valid});
            chk("if_id_inst", o_if_id_inst, e.inst);
            chk("if_id_pc", o_if_id_pc, e.pc);
            chk("if_id_pc4", o_if_id_pc4, e.pc4);
            chk("fetch_count", o_fetch_count, e.cnt);
            chk("misaligned", {31'd0, o_misaligned}, {31'd0, e.mis});
        end
    end

    task automatic model_reset();
        m_f      = RstAddr;
        m_since  = 0;
        m_id.inst  = Nop;
        m_id.pc    = 32'd0;
        m_id.pc4   = 32'd0;
        m_id.cnt   = 32'd0;
        m_id.valid = 1'b0;
        m_id.mis   = 1'b0;
    endtask

    // Called at a falling edge; leaves at the next falling edge.
    task automatic cycle(input logic sp, input logic sif, input logic rd, input logic [31:0] tgt);
        logic        w;
        logic [31:0] nxt;
        i_stall_pc        = sp;
        i_stall_if_id     = sif;
        i_redirect        = rd;
        i_redirect_target = tgt;
        #1;
        w = (m_since < WaitCyc);
        if (w) nxt = RstAddr;
        else if (rd) nxt = {tgt[31:2], 2'b00};
        else if (sp) nxt = m_f;
        else nxt = m_f + 32'd4;
        chk("imem_raddr", o_imem_raddr, nxt);
        chk("rst_stall", {31'd0, o_rst_stall}, {31'd0, w});
        if (!sif) begin
            if (w || rd) begin
                m_id.inst  = Nop;
                m_id.valid = 1'b0;
            end else begin
                m_id.inst  = mem_word(m_f);
                m_id.pc    = m_f;
                m_id.pc4   = m_f + 32'd4;
                m_id.valid = 1'b1;
                m_id.cnt   = m_id.cnt + 32'd1;
            end
        end
        if (!w && rd && (tgt[1:0] != 2'b00)) m_id.mis = 1'b1;
        m_f = nxt;
        if (m_since < 100) m_since++;
        q.push_back(m_id);
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_stall_pc = 1'b0;
        i_stall_if_id = 1'b0;
        i_redirect = 1'b0;
        #1;
        chk("rst_imem_ren", {31'd0, o_imem_ren}, 32'd0);
        chk("rst_rst_stall", {31'd0, o_rst_stall}, 32'd1);
        chk("rst_valid", {31'd0, o_if_id_valid}, 32'd0);
        chk("rst_inst", o_if_id_inst, Nop);
        chk("rst_pc", o_if_id_pc, 32'd0);
        chk("rst_pc4", o_if_id_pc4, 32'd0);
        chk("rst_count", o_fetch_count, 32'd0);
        chk("rst_misaligned", {31'd0, o_misaligned}, 32'd0);
        q.delete();
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            int unsigned sel;
            logic [31:0] t;
            sel = $urandom_range(0, 9);
            t = 32'h100 + ($urandom_range(0, 255) << 2);
            if (m_since < WaitCyc) cycle(1'($urandom), 1'($urandom), 1'($urandom), t);
            else if (sel < 2) cycle(1'b1, 1'b1, 1'b0, 32'd0);
            else if (sel == 2) cycle(1'($urandom), 1'b0, 1'b1, t);
            else cycle(1'b0, 1'b0, 1'b0, 32'd0);
        end
    endtask

    initial begin
        #2;
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 32'd0);   // WAIT cycle
        cycle(1'b0, 1'b0, 1'b0, 32'd0);   // 0x100 enters IF/ID
        cycle(1'b0, 1'b0, 1'b0, 32'd0);   // 0x104
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);   // 0x108
        cycle(1'b0, 1'b0, 1'b0, 32'd0);   // 0x10C
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);   // 0x200
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0180);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0202);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
        rand_cycles(400);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_02F8);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        do_reset();
        rand_cycles(200);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
